// File: rtl/epc_stack_unit_pkg.sv
// ---------------------------------------------------------------------------
// Module : epc_stack_unit_pkg
// Shared constants, enable/disable macros and entry tag type for the EPC stack.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef ENABLE
`define ENABLE 1'b1
`endif
`ifndef DISABLE
`define DISABLE 1'b0
`endif

package epc_stack_unit_pkg;
  localparam int EPC_WORD_W    = 32;
  localparam int EPC_BD_OFFSET = 4;

  typedef struct packed {
    logic err;
    logic bd;
  } epc_tag_t;
endpackage

`default_nettype wire

// File: rtl/epc_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// Module : epc_ptr_ctrl
// Top pointer, occupancy count, full/empty and sticky overflow for the EPC stack.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module epc_ptr_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       ovf_clr,
  output logic [$clog2(DEPTH)-1:0]   top_ptr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [PW-1:0] r_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  assign top_ptr  = r_ptr;
  assign count    = r_count;
  assign full     = (r_count == C_DEPTH);
  assign empty    = (r_count == '0);
  assign overflow = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_ovf   <= `DISABLE;
    end else begin
      // A push into a full stack wraps onto the oldest slot; count saturates.
      if (push) begin
        r_ptr <= r_ptr + PW'(1);
        if (!full) r_count <= r_count + CW'(1);
      end else if (pop && !empty) begin
        r_ptr   <= r_ptr - PW'(1);
        r_count <= r_count - CW'(1);
      end
      if (push && full)  r_ovf <= `ENABLE;
      else if (ovf_clr)  r_ovf <= `DISABLE;
    end
  end
endmodule

`default_nettype wire

// File: rtl/epc_stack_unit.sv
// ---------------------------------------------------------------------------
// Module : epc_stack_unit
// Circular stack of exception PCs with error/BD tags. Option: EPC_BD_ADJUST_EN.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module epc_stack_unit
  import epc_stack_unit_pkg::*;
#(
  parameter int WIDTH = EPC_WORD_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     exc_p,
  input  logic                     err_p,
  input  logic                     bd_p,
  input  logic [WIDTH-1:0]         pc_p,
  input  logic                     eret_p,
  input  logic                     we_s,
  input  logic [WIDTH-1:0]         write_data,
  input  logic                     ovf_clr,
  output logic [WIDTH-1:0]         read_data,
  output logic                     err_o,
  output logic                     bd_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     overflow_o
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_pc_mem  [DEPTH];
  epc_tag_t         r_tag_mem [DEPTH];

  logic [PW-1:0]    w_top;
  logic [PW-1:0]    w_slot;
  logic             w_push;
  logic             w_pop;
  logic             w_wr_top;
  logic [WIDTH-1:0] w_push_pc;
  epc_tag_t         w_push_tag;
  epc_tag_t         w_top_tag;
  logic [WIDTH-1:0] w_exc_pc;
  logic             w_exc_bd;

  // exc_p > eret_p > we_s; a software write into an empty stack acts as a push.
  assign w_push   = exc_p | (~eret_p & we_s & empty_o);
  assign w_pop    = ~exc_p & eret_p;
  assign w_wr_top = ~exc_p & ~eret_p & we_s & ~empty_o;
  assign w_slot   = w_top + PW'(1);

`ifdef EPC_BD_ADJUST_EN
  assign w_exc_pc = bd_p ? (pc_p - WIDTH'(EPC_BD_OFFSET)) : pc_p;
  assign w_exc_bd = bd_p;
`else
  logic w_unused;
  assign w_exc_pc = pc_p;
  assign w_exc_bd = 1'b0;
  assign w_unused = ^{bd_p, w_top_tag.bd};
`endif

  assign w_push_pc      = exc_p ? w_exc_pc : write_data;
  assign w_push_tag.err = exc_p & err_p;
  assign w_push_tag.bd  = exc_p & w_exc_bd;

  epc_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr_ctrl (
    .clk      (clk),
    .rst      (rst),
    .push     (w_push),
    .pop      (w_pop),
    .ovf_clr  (ovf_clr),
    .top_ptr  (w_top),
    .count    (count_o),
    .full     (full_o),
    .empty    (empty_o),
    .overflow (overflow_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]  <= '0;
        r_tag_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_pc_mem[w_slot]  <= w_push_pc;
      r_tag_mem[w_slot] <= w_push_tag;
    end else if (w_wr_top) begin
      r_pc_mem[w_top] <= write_data;
    end
  end

  assign w_top_tag = r_tag_mem[w_top];
  assign read_data = empty_o ? '0 : r_pc_mem[w_top];
  assign err_o     = ~empty_o & w_top_tag.err;
`ifdef EPC_BD_ADJUST_EN
  assign bd_o      = ~empty_o & w_top_tag.bd;
`else
  assign bd_o      = 1'b0;
`endif
endmodule

`default_nettype wire

// File: tb/tb_epc_stack_unit.sv
// ---------------------------------------------------------------------------
// Module : tb_epc_stack_unit
// Scoreboard bench: queue-based reference model, directed cases plus random traffic.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_epc_stack_unit;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef EPC_BD_ADJUST_EN
  localparam bit ADJ = 1'b1;
`else
  localparam bit ADJ = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             exc_p = 1'b0, err_p = 1'b0, bd_p = 1'b0;
  logic [WIDTH-1:0] pc_p = '0;
  logic             eret_p = 1'b0, we_s = 1'b0, ovf_clr = 1'b0;
  logic [WIDTH-1:0] write_data = '0;
  logic [WIDTH-1:0] read_data;
  logic             err_o, bd_o, full_o, empty_o, overflow_o;
  logic [CW-1:0]    count_o;

  epc_stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .exc_p(exc_p), .err_p(err_p), .bd_p(bd_p), .pc_p(pc_p),
    .eret_p(eret_p), .we_s(we_s), .write_data(write_data), .ovf_clr(ovf_clr),
    .read_data(read_data), .err_o(err_o), .bd_o(bd_o), .count_o(count_o),
    .full_o(full_o), .empty_o(empty_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] pc;
    bit               err;
    bit               bd;
  } ent_t;

  typedef struct {
    string                 nm;
    logic [WIDTH+CW+4:0]   v;
  } exp_t;

  ent_t mdl_q[$];
  bit   mdl_ovf;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: newest entry at the back of the queue.
  task automatic model_step(input bit r, e, er, b, input logic [WIDTH-1:0] pc,
                            input bit et, w, input logic [WIDTH-1:0] wd, input bit c);
    bit   set_ovf;
    ent_t en;
    set_ovf = 1'b0;
    if (r) begin
      mdl_q.delete();
      mdl_ovf = 1'b0;
    end else begin
      if (e) begin
        en.pc  = (ADJ && b) ? pc - 32'd4 : pc;
        en.err = er;
        en.bd  = ADJ && b;
        if (mdl_q.size() == DEPTH) begin
          void'(mdl_q.pop_front());
          set_ovf = 1'b1;
        end
        mdl_q.push_back(en);
      end else if (et) begin
        if (mdl_q.size() > 0) void'(mdl_q.pop_back());
      end else if (w) begin
        if (mdl_q.size() > 0) mdl_q[$].pc = wd;
        else begin
          en.pc = wd; en.err = 1'b0; en.bd = 1'b0;
          mdl_q.push_back(en);
        end
      end
      if (c) mdl_ovf = 1'b0;
      if (set_ovf) mdl_ovf = 1'b1;
    end
  endtask

  function automatic logic [WIDTH+CW+4:0] model_out();
    logic [WIDTH-1:0] rd;
    bit               te, tb;
    int               n;
    n  = mdl_q.size();
    rd = (n > 0) ? mdl_q[$].pc : '0;
    te = (n > 0) ? mdl_q[$].err : 1'b0;
    tb = (n > 0) ? mdl_q[$].bd : 1'b0;
    return {rd, te, tb, CW'(n), (n == DEPTH), (n == 0), mdl_ovf};
  endfunction

  task automatic drive(input string nm, input bit r, e, er, b, input logic [WIDTH-1:0] pc,
                       input bit et, w, input logic [WIDTH-1:0] wd, input bit c);
    exp_t x;
    @(negedge clk);
    #2;
    rst = r; exc_p = e; err_p = er; bd_p = b; pc_p = pc;
    eret_p = et; we_s = w; write_data = wd; ovf_clr = c;
    model_step(r, e, er, b, pc, et, w, wd, c);
    x.nm = nm;
    x.v  = model_out();
    exp_q.push_back(x);
  endtask

  task automatic idle(input string nm);
    drive(nm, 0, 0, 0, 0, '0, 0, 0, '0, 0);
  endtask

  task automatic push(input string nm, input logic [WIDTH-1:0] pc);
    drive(nm, 0, 1, 0, 0, pc, 0, 0, '0, 0);
  endtask

  task automatic pop(input string nm);
    drive(nm, 0, 0, 0, 0, '0, 1, 0, '0, 0);
  endtask

  task automatic do_rst(input string nm);
    drive(nm, 1, 0, 0, 0, '0, 0, 0, '0, 0);
  endtask

  // Monitor: outputs are state functions, so one expectation retires per cycle.
  always @(negedge clk) begin
    exp_t x;
    logic [WIDTH+CW+4:0] act;
    if (exp_q.size() > 0) begin
      x   = exp_q.pop_front();
      act = {read_data, err_o, bd_o, count_o, full_o, empty_o, overflow_o};
      n_checks++;
      if (act !== x.v) begin
        n_errors++;
        $display("FAIL %s: got rd=%h err=%b bd=%b cnt=%0d full=%b empty=%b ovf=%b, want rd=%h err=%b bd=%b cnt=%0d full=%b empty=%b ovf=%b",
                 x.nm, read_data, err_o, bd_o, count_o, full_o, empty_o, overflow_o,
                 x.v[WIDTH+CW+4:CW+5], x.v[CW+4], x.v[CW+3], x.v[CW+2:3], x.v[2], x.v[1], x.v[0]);
      end
    end
  end

  initial begin
    do_rst("reset");
    drive("bd_push", 0, 1, 1, 1, 32'h4, 0, 0, '0, 0);

    do_rst("reset2");
    push("fill10", 32'h10);
    push("fill20", 32'h20);
    push("fill30", 32'h30);
    push("fill40", 32'h40);
    push("fill50_ovf", 32'h50);
    for (int i = 0; i < 4; i++) pop("pop_seq");
    idle("empty_after_pops");

    do_rst("reset3");
    push("prio_pre", 32'h200);
    drive("prio_all", 0, 1, 0, 0, 32'h100, 1, 1, 32'hF, 0);
    drive("prio_eret_we", 0, 0, 0, 0, '0, 1, 1, 32'hF, 0);
    drive("we_top", 0, 0, 0, 0, '0, 0, 1, 32'hABCD, 0);

    do_rst("reset4");
    drive("we_empty", 0, 0, 0, 0, '0, 0, 1, 32'hF, 0);
    pop("we_pop");
    pop("pop_empty");

    for (int i = 0; i < 5; i++) push("ovf_fill", 32'h1000 + 32'(i));
    drive("ovf_clr", 0, 0, 0, 0, '0, 0, 0, '0, 1);
    drive("ovf_set_wins", 0, 1, 1, 0, 32'h77, 0, 0, '0, 1);
    push("mid_push", 32'h88);
    do_rst("rst_mid");
    pop("pop_after_rst");
    push("pre_rst_prio", 32'h99);
    drive("rst_prio", 1, 1, 1, 1, 32'h55, 1, 1, 32'h66, 0);
    drive("bd_pc0", 0, 1, 0, 1, 32'h0, 0, 0, '0, 0);

    for (int i = 0; i < 600; i++) begin
      int          k;
      logic [31:0] pcv;
      k   = $urandom_range(0, 99);
      pcv = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      drive("random", (k < 2), ($urandom_range(0, 99) < 35), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, pcv, ($urandom_range(0, 99) < 35),
            ($urandom_range(0, 99) < 25), $urandom, ($urandom_range(0, 99) < 10));
    end
    idle("final");

    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/epc_stack_unit.md
EPC_STACK_UNIT -- requirements
Module: epc_stack_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: PC and data width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: number of stacked exception-PC entries; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port exc_p, input, 1: exception commit pulse; pushes one entry.
REQ-006 SHALL have port err_p, input, 1: the pushed exception is error-class (cache error, NMI); tags the entry.
REQ-007 SHALL have port bd_p, input, 1: the faulting instruction sits in a branch delay slot.
REQ-008 SHALL have port pc_p, input, WIDTH: PC of the faulting instruction.
REQ-009 SHALL have port eret_p, input, 1: exception-return pulse; pops one entry.
REQ-010 SHALL have port we_s, input, 1: software (MTC0) write strobe to the top entry.
REQ-011 SHALL have port write_data, input, WIDTH: software write value.
REQ-012 SHALL have port ovf_clr, input, 1: clears the sticky overflow flag.
REQ-013 SHALL have port read_data, output, WIDTH: PC of the top entry; 0 when empty.
REQ-014 SHALL have port err_o, output, 1: error-class tag of the top entry; 0 when empty.
REQ-015 SHALL have port bd_o, output, 1: BD tag of the top entry; 0 when empty.
REQ-016 SHALL have port count_o, output, $clog2(DEPTH)+1: number of valid entries.
REQ-017 SHALL have ports full_o and empty_o, output, 1 each: count_o==DEPTH and count_o==0.
REQ-018 SHALL have port overflow_o, output, 1: sticky flag, set when a push drops the oldest entry.

Function
REQ-019 SHALL store the entries in a circular buffer addressed by a top pointer, modulo DEPTH.
REQ-020 SHALL make read_data, err_o, bd_o, count_o, full_o and empty_o registered-state functions; a push, pop or write becomes visible on them the cycle after the clock edge.
REQ-021 SHALL, on exc_p, advance the top pointer, write {pc, err_p, bd}, and increment count_o unless full_o is set.
REQ-022 SHALL, on exc_p while full_o is set, overwrite the oldest slot, hold count_o at DEPTH, and set overflow_o.
REQ-023 SHALL, on eret_p with count_o>0, retreat the top pointer and decrement count_o.
REQ-024 SHALL treat eret_p while empty as a no-op; count_o stays 0 and no flag changes.
REQ-025 SHALL, on we_s while count_o>0, replace the top entry's PC with write_data and leave its tags unchanged.
REQ-026 SHALL, on we_s while empty, push write_data with both tags clear (count_o becomes 1).
REQ-027 SHALL apply the priority exc_p > eret_p > we_s when they coincide; the lower-priority events in that cycle are discarded.
REQ-028 SHALL compute all PC arithmetic modulo 2^WIDTH; pc_p=0 with the BD adjustment stores all-ones minus 3.
REQ-029 SHALL clear overflow_o on ovf_clr; a set caused by a push in the same cycle wins.

Reset
REQ-030 SHALL, on rst, clear the pointer, count_o, overflow_o and every entry, giving read_data=0, err_o=0, bd_o=0, empty_o=1 and full_o=0.
REQ-031 SHALL give rst priority over all other inputs in the same cycle, including mid-sequence pushes and pops.

Configuration
REQ-032 SHALL, with macro EPC_BD_ADJUST_EN defined, store pc_p-4 and set the BD tag when bd_p=1.
REQ-033 SHALL, without EPC_BD_ADJUST_EN, store pc_p verbatim, ignore bd_p, and tie bd_o to 0.

Structure
REQ-034 SHALL take `ENABLE, `DISABLE, EPC_WORD_W (32) and EPC_BD_OFFSET (4) from the shared head.v header.
REQ-035 SHALL implement pointer, count, full/empty and overflow logic in a sub-module epc_ptr_ctrl; the storage array and tag muxing stay in epc_stack_unit.

Verification
REQ-036 SHALL check: rst 1 cycle -> read_data=0, count_o=0, empty_o=1, overflow_o=0.
REQ-037 SHALL check: exc_p with pc_p=0x4, bd_p=1, err_p=1 -> read_data=0x0, bd_o=1, err_o=1, count_o=1; without the macro -> read_data=0x4, bd_o=0.
REQ-038 SHALL check, with DEPTH=4: push PCs 0x10, 0x20, 0x30, 0x40, 0x50 -> full_o=1, overflow_o=1; then four eret_p pops -> read_data 0x50, 0x40, 0x30, 0x20, then empty_o=1.
REQ-039 SHALL check: exc_p, eret_p and we_s in the same cycle with write_data=0xF -> only the push occurs, read_data=pc_p, count_o incremented.
REQ-040 SHALL check: we_s with write_data=0xF while empty -> read_data=0xF, count_o=1; a following eret_p -> empty_o=1; a further eret_p -> no change.
REQ-041 SHALL check: overflow_o set, then ovf_clr -> overflow_o=0; rst asserted between a push and a pop -> all reset values the next cycle.
